// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds FSM/owner encodings, access-length codes and the length-to-bytecount helper.
package mem_ctrl_pkg;

    localparam int ADDR_W = 32;

    localparam logic RESET_ENABLE  = 1'b1;
    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;

    localparam logic [1:0] MEM_LEN_B = 2'd0;
    localparam logic [1:0] MEM_LEN_H = 2'd1;
    localparam logic [1:0] MEM_LEN_W = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // The illegal length code 2 is served as a full word.
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            MEM_LEN_B: n = 3'd1;
            MEM_LEN_H: n = 3'd2;
            MEM_LEN_W: n = 3'd4;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline-side and RAM-side signal bundle of the memory controller.
// slave = controller view, master = requester/RAM view.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              stall_req_if;
    logic              stall_req_mem;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        output if_data, if_done, mem_rdata, mem_done, stall_req_if, stall_req_mem,
               ram_dout, ram_a, ram_wr
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        input  if_data, if_done, mem_rdata, mem_done, stall_req_if, stall_req_mem,
               ram_dout, ram_a, ram_wr
    );

endinterface

// File: rtl/mem_ctrl_byte_buf.sv
// 4x8 byte buffer: assembles read bytes into a word and hands out store bytes by index.
// o_merged shows the word with the pending byte already inserted.
module mem_ctrl_byte_buf
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_init,
    input  logic        i_wr,
    input  logic [1:0]  i_idx,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_merged,
    output logic [7:0]  o_byte
);

    logic [31:0] r_word;
    logic [31:0] w_merged;

    // Word with the incoming byte substituted at i_idx.
    always_comb begin
        w_merged = r_word;
        if (i_wr) begin
            w_merged[{i_idx, 3'b000} +: 8] = i_byte;
        end else begin
            w_merged = r_word;
        end
    end

    // Buffer storage: bulk load or single-byte update.
    always_ff @(posedge clk) begin
        if (rst == RESET_ENABLE) begin
            r_word <= 32'd0;
        end else if (i_load) begin
            r_word <= i_init;
        end else if (i_wr) begin
            r_word <= w_merged;
        end else begin
            r_word <= r_word;
        end
    end

    assign o_merged = w_merged;
    assign o_byte   = r_word[{i_idx, 3'b000} +: 8];

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch vs load/store (MEM first) and serializes each
// access into byte cycles on a single-port RAM with one cycle of read latency.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    state_t            r_state;
    owner_t            r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_n;
    logic [2:0]        r_cnt;

    logic [2:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_buf_load;
    logic [31:0]       w_buf_init;
    logic              w_buf_wr;
    logic [1:0]        w_buf_idx;
    logic [31:0]       w_buf_merged;
    logic [7:0]        w_buf_byte;

    // Next byte index/address and byte-buffer steering.
    always_comb begin
        w_cnt_nxt  = r_cnt + 3'd1;
        w_addr_nxt = r_addr + {{(ADDR_W-3){1'b0}}, w_cnt_nxt};
        w_buf_load = (r_state == ST_IDLE);
        w_buf_init = (bus.mem_req && bus.mem_we) ? bus.mem_wdata : 32'd0;
        w_buf_wr   = (r_state == ST_RD) && (r_cnt != 3'd0);
        if (r_state == ST_WR) begin
            w_buf_idx = r_cnt[1:0] + 2'd1;
        end else begin
            w_buf_idx = r_cnt[1:0] - 2'd1;
        end
    end

    mem_ctrl_byte_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_buf_load),
        .i_init   (w_buf_init),
        .i_wr     (w_buf_wr),
        .i_idx    (w_buf_idx),
        .i_byte   (bus.ram_din),
        .o_merged (w_buf_merged),
        .o_byte   (w_buf_byte)
    );

    assign bus.stall_req_if  = (bus.if_req && !bus.if_done)   ? STALL_ENABLE : STALL_DISABLE;
    assign bus.stall_req_mem = (bus.mem_req && !bus.mem_done) ? STALL_ENABLE : STALL_DISABLE;

    // Controller FSM with all RAM and pipeline outputs registered.
    always_ff @(posedge clk) begin
        if (rst == RESET_ENABLE) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_IF;
            r_addr        <= '0;
            r_n           <= 3'd0;
            r_cnt         <= 3'd0;
            bus.if_done   <= 1'b0;
            bus.mem_done  <= 1'b0;
            bus.if_data   <= 32'd0;
            bus.mem_rdata <= 32'd0;
            bus.ram_wr    <= 1'b0;
            bus.ram_a     <= '0;
            bus.ram_dout  <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    bus.if_done  <= 1'b0;
                    bus.mem_done <= 1'b0;
                    bus.ram_wr   <= 1'b0;
                    bus.ram_dout <= 8'd0;
                    r_cnt        <= 3'd0;
                    if (bus.mem_req) begin
                        r_owner   <= OWN_MEM;
                        r_addr    <= bus.mem_addr;
                        r_n       <= len_to_n(bus.mem_len);
                        bus.ram_a <= bus.mem_addr;
                        if (bus.mem_we) begin
                            r_state      <= ST_WR;
                            bus.ram_wr   <= 1'b1;
                            bus.ram_dout <= bus.mem_wdata[7:0];
                        end else begin
                            r_state <= ST_RD;
                        end
                    end else if (bus.if_req) begin
                        r_owner   <= OWN_IF;
                        r_addr    <= bus.if_addr;
                        r_n       <= 3'd4;
                        bus.ram_a <= bus.if_addr;
                        r_state   <= ST_RD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    // A withdrawn fetch (branch flush) is dropped without a done pulse.
                    if ((r_owner == OWN_IF) && !bus.if_req) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == r_n) begin
                        r_state <= ST_DONE;
                        if (r_owner == OWN_IF) begin
                            bus.if_data <= w_buf_merged;
                            bus.if_done <= 1'b1;
                        end else begin
                            bus.mem_rdata <= w_buf_merged;
                            bus.mem_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt < r_n) begin
                            bus.ram_a <= w_addr_nxt;
                        end else begin
                            bus.ram_a <= bus.ram_a;
                        end
                    end
                end
                ST_WR: begin
                    if (w_cnt_nxt < r_n) begin
                        r_cnt        <= w_cnt_nxt;
                        bus.ram_a    <= w_addr_nxt;
                        bus.ram_dout <= w_buf_byte;
                    end else begin
                        r_state      <= ST_DONE;
                        bus.ram_wr   <= 1'b0;
                        bus.ram_dout <= 8'd0;
                        bus.mem_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    bus.if_done  <= 1'b0;
                    bus.mem_done <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random transactions
// checked against a transaction-level RAM model.
module tb_mem_ctrl;

    logic clk;
    logic rst;
    logic dev_clear;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [7:0] dev_m [0:4095];
    logic [7:0] ref_m [0:4095];

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        return 8'(a * 7 + 3) ^ 8'h5A;
    endfunction

    // RAM device: one cycle from address to data, write on the clock edge.
    always @(posedge clk) begin
        if (dev_clear) begin
            for (int i = 0; i < 4096; i++) dev_m[i] <= pat(i);
            bus.ram_din <= 8'd0;
        end else begin
            bus.ram_din <= dev_m[bus.ram_a[11:0]];
            if (bus.ram_wr) dev_m[bus.ram_a[11:0]] <= bus.ram_dout;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr, input int n);
        logic [31:0] w;
        logic [31:0] a;
        w = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            w[8*i +: 8] = ref_m[a[11:0]];
        end
        return w;
    endfunction

    // One complete transaction, entered #1 after a rising edge with the DUT idle.
    task automatic txn(input bit is_if, input bit we, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] got);
        int n, lat, c, wr_cyc, seq_err;
        logic [31:0] exp, a;
        bit done_seen;
        if (is_if) we = 1'b0;
        n   = is_if ? 4 : ((len == 2'd2) ? 4 : int'(len) + 1);
        lat = we ? n + 1 : n + 2;
        exp = ref_word(addr, n);
        if (we) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                ref_m[a[11:0]] = wd[8*i +: 8];
            end
        end
        if (is_if) begin
            bus.if_addr = addr;
            bus.if_req  = 1'b1;
        end else begin
            bus.mem_addr  = addr;
            bus.mem_we    = we;
            bus.mem_len   = len;
            bus.mem_wdata = wd;
            bus.mem_req   = 1'b1;
        end
        c = 0; wr_cyc = 0; seq_err = 0; done_seen = 1'b0;
        while (!done_seen && c <= lat + 4) begin
            @(negedge clk);
            if (c == 0) chk_eq("stall_during", 32'(is_if ? bus.stall_req_if : bus.stall_req_mem), 32'd1);
            if (bus.ram_wr) wr_cyc++;
            if (c >= 1 && c <= n) begin
                if (bus.ram_a !== addr + 32'(c - 1)) seq_err++;
                if (we && bus.ram_dout !== wd[8*(c-1) +: 8]) seq_err++;
            end else if (c > n && bus.ram_dout !== 8'd0) begin
                seq_err++;
            end
            if (is_if ? bus.mem_done : bus.if_done) seq_err++;
            done_seen = is_if ? bus.if_done : bus.mem_done;
            if (!done_seen) c++;
        end
        got = is_if ? bus.if_data : bus.mem_rdata;
        chk_eq("latency", 32'(c), 32'(lat));
        chk_eq("ram_wr_cycles", 32'(wr_cyc), we ? 32'(n) : 32'd0);
        chk_eq("ram_sequence_errors", 32'(seq_err), 32'd0);
        if (!we) chk_eq(is_if ? "if_data" : "mem_rdata", got, exp);
        @(posedge clk);
        #1;
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        @(negedge clk);
        chk_eq("stall_after", 32'(is_if ? bus.stall_req_if : bus.stall_req_mem), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, exp_m, exp_i;
        int c, mem_c, if_c, st_err;
        bit r_if, r_we;
        logic [1:0] r_len;
        logic [31:0] r_addr, r_wd;

        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'd0;
        bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
        rst = 1'b1; dev_clear = 1'b1;
        for (int i = 0; i < 4096; i++) ref_m[i] = pat(i);
        repeat (3) @(posedge clk);
        #1 dev_clear = 1'b0;
        @(negedge clk);
        chk_eq("rst_if_done", 32'(bus.if_done), 32'd0);
        chk_eq("rst_mem_done", 32'(bus.mem_done), 32'd0);
        chk_eq("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
        chk_eq("rst_ram_a", bus.ram_a, 32'd0);
        chk_eq("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
        chk_eq("rst_if_data", bus.if_data, 32'd0);
        chk_eq("rst_mem_rdata", bus.mem_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // T1: preload 13,00,50,00 at 0x100 through a store, then fetch it.
        txn(1'b0, 1'b1, 2'd3, 32'h100, 32'h00500013, got);
        txn(1'b1, 1'b0, 2'd0, 32'h100, 32'd0, got);
        chk_eq("t1_if_data", got, 32'h00500013);

        // T2: byte and half loads.
        txn(1'b0, 1'b0, 2'd0, 32'h101, 32'd0, got);
        chk_eq("t2_byte", got, 32'h00000000);
        txn(1'b0, 1'b1, 2'd1, 32'h102, 32'h0000FF80, got);
        txn(1'b0, 1'b0, 2'd1, 32'h102, 32'd0, got);
        chk_eq("t2_half", got, 32'h0000FF80);

        // T3: word store and read-back.
        txn(1'b0, 1'b1, 2'd3, 32'h200, 32'hDEADBEEF, got);
        txn(1'b0, 1'b0, 2'd3, 32'h200, 32'd0, got);
        chk_eq("t3_readback", got, 32'hDEADBEEF);

        // T4: simultaneous requests, MEM first.
        exp_m = ref_word(32'h100, 4);
        exp_i = ref_word(32'h104, 4);
        bus.mem_addr = 32'h100; bus.mem_we = 1'b0; bus.mem_len = 2'd3; bus.mem_req = 1'b1;
        bus.if_addr = 32'h104; bus.if_req = 1'b1;
        c = 0; mem_c = -1; if_c = -1; st_err = 0;
        while (if_c < 0 && c < 40) begin
            @(negedge clk);
            if (bus.mem_done) begin
                mem_c = c;
                chk_eq("t4_mem_rdata", bus.mem_rdata, exp_m);
            end
            if (bus.if_done) begin
                if_c = c;
                chk_eq("t4_if_data", bus.if_data, exp_i);
            end else if (!bus.stall_req_if) begin
                st_err++;
            end
            @(posedge clk);
            #1;
            if (mem_c >= 0) bus.mem_req = 1'b0;
            if (if_c >= 0) bus.if_req = 1'b0;
            c++;
        end
        chk_eq("t4_mem_latency", 32'(mem_c), 32'd6);
        chk_eq("t4_if_latency", 32'(if_c), 32'd13);
        chk_eq("t4_stall_if_held", 32'(st_err), 32'd0);

        // T5: fetch withdrawn two cycles in; a load must start on the very next cycle.
        bus.if_addr = 32'h40; bus.if_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 2'd3, 32'h80, 32'd0, got);

        // T6: reset in the middle of a store.
        bus.mem_addr = 32'h300; bus.mem_we = 1'b1; bus.mem_len = 2'd3;
        bus.mem_wdata = 32'h11223344; bus.mem_req = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk_eq("t6_ram_wr", 32'(bus.ram_wr), 32'd0);
        chk_eq("t6_mem_done", 32'(bus.mem_done), 32'd0);
        chk_eq("t6_ram_a", bus.ram_a, 32'd0);
        chk_eq("t6_ram_dout", 32'(bus.ram_dout), 32'd0);
        chk_eq("t6_if_data", bus.if_data, 32'd0);
        chk_eq("t6_mem_rdata", bus.mem_rdata, 32'd0);
        bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        txn(1'b1, 1'b0, 2'd0, 32'h100, 32'd0, got);

        // Random traffic against the reference memory.
        for (int k = 0; k < 60; k++) begin
            r_if   = 1'($urandom_range(0, 1));
            r_we   = 1'($urandom_range(0, 1));
            r_len  = 2'($urandom_range(0, 3));
            r_addr = 32'($urandom_range(0, 32'h1FF));
            r_wd   = $urandom;
            txn(r_if, r_we, r_len, r_addr, r_wd, got);
        end

        // Address wrap at the top of the space.
        txn(1'b0, 1'b1, 2'd3, 32'hFFFFFFFE, 32'hCAFEF00D, got);
        txn(1'b0, 1'b0, 2'd3, 32'hFFFFFFFE, 32'd0, got);
        chk_eq("wrap_rdata", got, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
